// File: rtl/div8bit_seq_pkg.sv
// Shared types and sizes for the sequential unsigned divider.
// Kept separate so the step and top agree on width and state encoding.
package div8bit_seq_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div8bit_seq_step.sv
// One restoring shift-subtract step, purely combinational.
// R' - B is formed as R' + ~B + 1; the carry out means no borrow.
import div8bit_seq_pkg::*;

module div8bit_seq_step #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   r_next,
    output logic             q
);

    logic [WIDTH:0]   r_sh;
    logic [WIDTH+1:0] sum;

    assign r_sh = {r[WIDTH-1:0], bit_in};
    assign sum  = {1'b0, r_sh}
                + {1'b0, ~{1'b0, b}}
                + {{(WIDTH+1){1'b0}}, 1'b1};

    // A set top bit in r means R' already exceeds any divisor.
    assign q      = sum[WIDTH+1] | r[WIDTH];
    assign r_next = q ? sum[WIDTH:0] : r_sh;

endmodule

// File: rtl/div8bit_seq.sv
// Sequential unsigned divider: one quotient bit per clock.
// FSM, counter and result registers; the arithmetic lives in the step.
import div8bit_seq_pkg::*;

module div8bit_seq #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    state_t           state, state_nx;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   step_r;
    logic             step_q;
    logic             accept;
    logic             last;

    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);
    assign accept = start && !busy;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    div8bit_seq_step #(.WIDTH(WIDTH)) u_step (
        .r      (r),
        .bit_in (dividend[WIDTH-1]),
        .b      (divisor),
        .r_next (step_r),
        .q      (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept) state_nx = (B == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (last) state_nx = S_DONE;
            end
            S_DONE: begin
                if (accept) state_nx = (B == '0) ? S_DONE : S_RUN;
                else        state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend  <= '0;
            divisor   <= '0;
            r         <= '0;
            cnt       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
        end else if (accept) begin
            dividend <= A;
            divisor  <= B;
            r        <= '0;
            cnt      <= '0;
            // Zero divisor finishes immediately with saturated quotient.
            if (B == '0) begin
                Quotient  <= '1;
                Remainder <= A;
                DivByZero <= 1'b1;
            end else begin
                Quotient  <= '0;
                Remainder <= '0;
                DivByZero <= 1'b0;
            end
        end else if (busy) begin
            r        <= step_r;
            dividend <= {dividend[WIDTH-2:0], step_q};
            cnt      <= cnt + 1'b1;
            if (last) begin
                Quotient  <= {dividend[WIDTH-2:0], step_q};
                Remainder <= step_r[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_div8bit_seq.sv
// Scoreboard bench for div8bit_seq: stimulus pushes expected ops,
// a monitor pops on every done and checks against plain arithmetic.
module tb_div8bit_seq;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         cyc;
    } op_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       DivByZero;

    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    op_t sb[$];
    op_t mon_e;

    div8bit_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done must match the oldest accepted operation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.b == 8'd0) begin
                    chk("dz_flag", int'(DivByZero), 1);
                    chk("dz_quot", int'(Quotient), 255);
                    chk("dz_rem", int'(Remainder), int'(mon_e.a));
                    chk("dz_latency", cyc - mon_e.cyc, 1);
                end else begin
                    chk("quot", int'(Quotient), int'(mon_e.a) / int'(mon_e.b));
                    chk("rem", int'(Remainder), int'(mon_e.a) % int'(mon_e.b));
                    chk("dz_clear", int'(DivByZero), 0);
                    chk("rem_lt_b", int'(Remainder < mon_e.b), 1);
                    chk("recompose",
                        int'(Quotient) * int'(mon_e.b) + int'(Remainder),
                        int'(mon_e.a));
                    chk("latency", cyc - mon_e.cyc, 9);
                end
            end
        end
    end

    // Called at a negedge; drives start for one cycle.
    task automatic pulse(input logic [7:0] a, input logic [7:0] b);
        op_t o;
        start = 1'b1;
        A = a;
        B = b;
        if (!busy) begin
            o.a = a;
            o.b = b;
            o.cyc = cyc;
            sb.push_back(o);
        end
        @(negedge clk);
        start = 1'b0;
        A = $urandom();
        B = $urandom();
    endtask

    task automatic drain(input string name);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) break;
        end
        if (k == 40) begin
            chk({name, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 40; k++) begin
            if (done) break;
            @(negedge clk);
        end
        if (k == 40) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quot", int'(Quotient), 0);
        chk("rst_rem", int'(Remainder), 0);
        chk("rst_dz", int'(DivByZero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        pulse(8'd200, 8'd7);
        chk("busy_after_accept", int'(busy), 1);
        drain("normal");
        pulse(8'd255, 8'd1);
        drain("e255");
        pulse(8'd5, 8'd9);
        drain("e5");
        pulse(8'd0, 8'd3);
        drain("e0");

        pulse(8'd13, 8'd0);
        chk("dz_busy", int'(busy), 0);
        drain("divzero");

        pulse(8'd100, 8'd10);
        repeat (2) @(negedge clk);
        pulse(8'd9, 8'd2);
        drain("ignore_run");

        pulse(8'd200, 8'd7);
        wait_done("held");
        pulse(8'd9, 8'd2);
        drain("held");
        chk("hold_quot", int'(Quotient), 4);
        chk("hold_rem", int'(Remainder), 1);

        pulse(8'd250, 8'd3);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_quot", int'(Quotient), 0);
        chk("arst_rem", int'(Remainder), 0);
        chk("arst_dz", int'(DivByZero), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse(8'd250, 8'd3);
        drain("after_reset");
        chk("post_quot", int'(Quotient), 83);
        chk("post_rem", int'(Remainder), 1);

        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 99) < 30)
                pulse(8'($urandom()), 8'($urandom_range(1, 255)));
            else
                @(negedge clk);
        end
        drain("random");
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
